// File: rtl/execute_mdu.sv
// Execute stage: single-cycle ALU, operand forwarding, branch/jump
// resolution and an iterative RV M-extension multiply/divide unit that
// stalls the front of the pipeline until its result is ready.
module execute_mdu #(
  parameter int XLEN     = 32,
  parameter int FAST_MUL = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] PIP_pc_i,
  input  logic [XLEN-1:0] PIP_operand1_i,
  input  logic [XLEN-1:0] PIP_operand2_i,
  input  logic [XLEN-1:0] PIP_immediate_i,
  input  logic [4:0]      PIP_rd_i,
  input  logic [3:0]      PIP_aluOper_i,
  input  logic            PIP_use_imm_i,
  input  logic            PIP_use_pc_i,
  input  logic            PIP_use_zero_i,
  input  logic            PIP_md_valid_i,
  input  logic [2:0]      PIP_md_oper_i,
  input  logic [1:0]      PIP_bnj_oper_i,
  input  logic            PIP_is_bnj_i,
  input  logic            PIP_bnj_neg_i,
  input  logic [4:0]      PIP_memOper_i,
  input  logic            PIP_use_mem_i,
  input  logic            PIP_write_reg_i,
  input  logic            PIP_TRAP_i,
  input  logic            use_EX_MEM_rs1_i,
  input  logic            use_EX_MEM_rs2_i,
  input  logic            use_MEM_WB_rs1_i,
  input  logic            use_MEM_WB_rs2_i,
  input  logic [XLEN-1:0] EX_MEM_operand_i,
  input  logic [XLEN-1:0] MEM_WB_operand_i,
  output logic [4:0]      PIP_memOper_o,
  output logic [XLEN-1:0] PIP_alu_result_o,
  output logic [XLEN-1:0] PIP_second_operand_o,
  output logic            PIP_use_mem_o,
  output logic            PIP_write_reg_o,
  output logic            PIP_TRAP_o,
  output logic [4:0]      PIP_rd_o,
  output logic            PC_load_target_o,
  output logic [XLEN-1:0] PC_target_address_o,
  output logic            stall_o
);

  localparam int SHW = $clog2(XLEN);
  localparam int W2  = 2 * XLEN;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_XOR  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SEQ  = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_SRL  = 4'd10;

  localparam logic [2:0] MD_MUL = 3'd0;

  localparam logic [XLEN-1:0] XMIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] XONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] XZERO = {XLEN{1'b0}};
  localparam logic [SHW-1:0]  LAST_COUNT = SHW'(XLEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  // Datapath signals
  logic [XLEN-1:0] operand1_s, new_rs2_s, operand2_s, alu_res_s;
  logic [SHW-1:0]  shamt_s;
  logic            branch_taken_s;
  logic            stall_s;

  // MDU state and registers
  md_state_e       state_q, state_d;
  logic [W2-1:0]   work_q, work_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic            spec_q, spec_d;
  logic [SHW-1:0]  count_q, count_d;

  // MDU decode of the incoming instruction
  logic            start_s, is_div_s, is_rem_s, a_signed_s, b_signed_s;
  logic            neg_a_s, neg_b_s, div_zero_s, div_ovf_s, special_s, fast_s;
  logic [XLEN-1:0] mag_a_s, mag_b_s, spec_res_s;
  logic            neg_res_s;

  // Iteration step and result correction
  logic [XLEN:0]   mul_sum_s, div_tmp_s, div_diff_s;
  logic [W2-1:0]   mul_next_s, div_next_s, prod_s;
  logic [XLEN-1:0] quo_s, rem_s, mdu_res_s;

  // EX/MEM register
  logic [4:0]      mem_oper_q, mem_oper_d;
  logic [XLEN-1:0] alu_result_q, alu_result_d;
  logic [XLEN-1:0] second_q, second_d;
  logic            use_mem_q, use_mem_d;
  logic            write_reg_q, write_reg_d;
  logic            trap_q, trap_d;
  logic [4:0]      rd_q, rd_d;

  // Operand selection with forwarding (EX/MEM beats MEM/WB)
  always_comb begin
    operand1_s = PIP_operand1_i;
    new_rs2_s  = PIP_operand2_i;
    if (PIP_use_zero_i) begin
      operand1_s = XZERO;
    end else if (PIP_use_pc_i) begin
      operand1_s = PIP_pc_i;
    end else if (use_EX_MEM_rs1_i) begin
      operand1_s = EX_MEM_operand_i;
    end else if (use_MEM_WB_rs1_i) begin
      operand1_s = MEM_WB_operand_i;
    end else begin
      operand1_s = PIP_operand1_i;
    end
    if (use_EX_MEM_rs2_i) begin
      new_rs2_s = EX_MEM_operand_i;
    end else if (use_MEM_WB_rs2_i) begin
      new_rs2_s = MEM_WB_operand_i;
    end else begin
      new_rs2_s = PIP_operand2_i;
    end
    operand2_s = PIP_use_imm_i ? PIP_immediate_i : new_rs2_s;
    shamt_s    = operand2_s[SHW-1:0];
  end

  // Single-cycle ALU
  always_comb begin
    alu_res_s = XZERO;
    case (PIP_aluOper_i)
      ALU_ADD:  alu_res_s = operand1_s + operand2_s;
      ALU_SUB:  alu_res_s = operand1_s - operand2_s;
      ALU_AND:  alu_res_s = operand1_s & operand2_s;
      ALU_XOR:  alu_res_s = operand1_s ^ operand2_s;
      ALU_OR:   alu_res_s = operand1_s | operand2_s;
      ALU_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, ($signed(operand1_s) < $signed(operand2_s))};
      ALU_SLTU: alu_res_s = {{(XLEN-1){1'b0}}, (operand1_s < operand2_s)};
      ALU_SEQ:  alu_res_s = {{(XLEN-1){1'b0}}, (operand1_s == operand2_s)};
      ALU_SLL:  alu_res_s = operand1_s << shamt_s;
      ALU_SRA:  alu_res_s = $unsigned($signed(operand1_s) >>> shamt_s);
      ALU_SRL:  alu_res_s = operand1_s >> shamt_s;
      default:  alu_res_s = XZERO;
    endcase
  end

  // Branch/jump resolution; a stalled instruction must not redirect the PC
  always_comb begin
    branch_taken_s = PIP_is_bnj_i & (PIP_bnj_oper_i[1] | (alu_res_s[0] ^ PIP_bnj_neg_i));
  end

  assign PC_load_target_o    = branch_taken_s & ~stall_s;
  assign PC_target_address_o = (PIP_bnj_oper_i[0] ? operand1_s : PIP_pc_i) + PIP_immediate_i;
  assign stall_o             = stall_s;

  // Decode the M-extension op sitting in ID/EX: signedness, magnitudes, special cases
  always_comb begin
    start_s    = PIP_md_valid_i & ~PIP_TRAP_i;
    is_div_s   = PIP_md_oper_i[2];
    is_rem_s   = PIP_md_oper_i[2] & PIP_md_oper_i[1];
    if (is_div_s) begin
      a_signed_s = ~PIP_md_oper_i[0];
      b_signed_s = ~PIP_md_oper_i[0];
    end else begin
      a_signed_s = (PIP_md_oper_i[1:0] != 2'b11);
      b_signed_s = ~PIP_md_oper_i[1];
    end
    neg_a_s    = a_signed_s & operand1_s[XLEN-1];
    neg_b_s    = b_signed_s & new_rs2_s[XLEN-1];
    mag_a_s    = neg_a_s ? -operand1_s : operand1_s;
    mag_b_s    = neg_b_s ? -new_rs2_s : new_rs2_s;
    neg_res_s  = is_rem_s ? neg_a_s : (neg_a_s ^ neg_b_s);
    div_zero_s = is_div_s & (new_rs2_s == XZERO);
    div_ovf_s  = is_div_s & b_signed_s & (operand1_s == XMIN) & (new_rs2_s == XONES);
    special_s  = div_zero_s | div_ovf_s;
    fast_s     = (FAST_MUL != 0) & ~is_div_s;
    if (div_zero_s) begin
      spec_res_s = is_rem_s ? operand1_s : XONES;
    end else if (div_ovf_s) begin
      spec_res_s = is_rem_s ? XZERO : XMIN;
    end else begin
      spec_res_s = XZERO;
    end
  end

  // MDU state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // MDU next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          state_d = (special_s | fast_s) ? ST_DONE : ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (count_q == LAST_COUNT) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // MDU outputs: stall from the issue cycle until the result cycle
  always_comb begin
    stall_s = 1'b0;
    case (state_q)
      ST_IDLE: stall_s = start_s;
      ST_BUSY: stall_s = 1'b1;
      ST_DONE: stall_s = 1'b0;
      default: stall_s = 1'b0;
    endcase
  end

  // One iteration: shift-add multiply (right shift) or restoring divide (left shift)
  always_comb begin
    mul_sum_s  = {1'b0, work_q[W2-1:XLEN]} + {1'b0, mcand_q};
    if (work_q[0]) begin
      mul_next_s = {mul_sum_s, work_q[XLEN-1:1]};
    end else begin
      mul_next_s = {1'b0, work_q[W2-1:1]};
    end
    div_tmp_s  = work_q[W2-1:XLEN-1];
    div_diff_s = div_tmp_s - {1'b0, mcand_q};
    if (!div_diff_s[XLEN]) begin
      div_next_s = {div_diff_s[XLEN-1:0], work_q[XLEN-2:0], 1'b1};
    end else begin
      div_next_s = {div_tmp_s[XLEN-1:0], work_q[XLEN-2:0], 1'b0};
    end
  end

  // MDU datapath: latch operands at issue, iterate while busy, hold otherwise
  always_comb begin
    work_d  = work_q;
    mcand_d = mcand_q;
    op_d    = op_q;
    neg_d   = neg_q;
    spec_d  = spec_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          mcand_d = mag_b_s;
          op_d    = PIP_md_oper_i;
          neg_d   = neg_res_s;
          spec_d  = special_s;
          count_d = {SHW{1'b0}};
          if (special_s) begin
            work_d = {XZERO, spec_res_s};
          end else if (fast_s) begin
            work_d = {XZERO, mag_a_s} * {XZERO, mag_b_s};
          end else begin
            work_d = {XZERO, mag_a_s};
          end
        end else begin
          work_d = work_q;
        end
      end
      ST_BUSY: begin
        work_d  = op_q[2] ? div_next_s : mul_next_s;
        count_d = count_q + SHW'(1);
      end
      ST_DONE: work_d = work_q;
      default: work_d = work_q;
    endcase
  end

  // MDU registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      work_q  <= {W2{1'b0}};
      mcand_q <= XZERO;
      op_q    <= 3'd0;
      neg_q   <= 1'b0;
      spec_q  <= 1'b0;
      count_q <= {SHW{1'b0}};
    end else begin
      work_q  <= work_d;
      mcand_q <= mcand_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      spec_q  <= spec_d;
      count_q <= count_d;
    end
  end

  // Sign-correct the magnitude result and pick the requested half
  always_comb begin
    prod_s = neg_q ? -work_q : work_q;
    quo_s  = work_q[XLEN-1:0];
    rem_s  = work_q[W2-1:XLEN];
    if (spec_q) begin
      mdu_res_s = work_q[XLEN-1:0];
    end else if (!op_q[2]) begin
      mdu_res_s = (op_q == MD_MUL) ? prod_s[XLEN-1:0] : prod_s[W2-1:XLEN];
    end else if (op_q[1]) begin
      mdu_res_s = neg_q ? -rem_s : rem_s;
    end else begin
      mdu_res_s = neg_q ? -quo_s : quo_s;
    end
  end

  // EX/MEM next value: bubble while stalled, MDU result in DONE, ALU otherwise
  always_comb begin
    mem_oper_d   = PIP_memOper_i;
    use_mem_d    = PIP_use_mem_i;
    write_reg_d  = PIP_write_reg_i;
    trap_d       = PIP_TRAP_i;
    rd_d         = PIP_rd_i;
    second_d     = new_rs2_s;
    alu_result_d = alu_res_s;
    if (stall_s) begin
      mem_oper_d   = 5'd0;
      use_mem_d    = 1'b0;
      write_reg_d  = 1'b0;
      trap_d       = 1'b0;
      rd_d         = 5'd0;
      second_d     = XZERO;
      alu_result_d = XZERO;
    end else if (state_q == ST_DONE) begin
      alu_result_d = mdu_res_s;
    end else if (PIP_is_bnj_i & PIP_bnj_oper_i[1]) begin
      alu_result_d = PIP_pc_i + XLEN'(4);
    end else begin
      alu_result_d = alu_res_s;
    end
  end

  // EX/MEM pipeline register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_oper_q   <= 5'd0;
      alu_result_q <= XZERO;
      second_q     <= XZERO;
      use_mem_q    <= 1'b0;
      write_reg_q  <= 1'b0;
      trap_q       <= 1'b0;
      rd_q         <= 5'd0;
    end else begin
      mem_oper_q   <= mem_oper_d;
      alu_result_q <= alu_result_d;
      second_q     <= second_d;
      use_mem_q    <= use_mem_d;
      write_reg_q  <= write_reg_d;
      trap_q       <= trap_d;
      rd_q         <= rd_d;
    end
  end

  assign PIP_memOper_o        = mem_oper_q;
  assign PIP_alu_result_o     = alu_result_q;
  assign PIP_second_operand_o = second_q;
  assign PIP_use_mem_o        = use_mem_q;
  assign PIP_write_reg_o      = write_reg_q;
  assign PIP_TRAP_o           = trap_q;
  assign PIP_rd_o             = rd_q;

endmodule

// File: tb/tb_execute_mdu.sv
// Directed testbench for execute_mdu (XLEN=32, iterative multiply).
module tb_execute_mdu;

  logic        clk;
  logic        reset_n;
  logic [31:0] pc, op1, op2, imm;
  logic [4:0]  rd;
  logic [3:0]  alu_op;
  logic        use_imm, use_pc, use_zero, md_valid;
  logic [2:0]  md_op;
  logic [1:0]  bnj_op;
  logic        is_bnj, bnj_neg;
  logic [4:0]  mem_op;
  logic        use_mem, write_reg, trap;
  logic        fw_em1, fw_em2, fw_mw1, fw_mw2;
  logic [31:0] em_val, mw_val;
  logic [4:0]  mem_op_o;
  logic [31:0] alu_o, second_o;
  logic        use_mem_o, write_reg_o, trap_o;
  logic [4:0]  rd_o;
  logic        load_o;
  logic [31:0] target_o;
  logic        stall_o;

  int n_checks;
  int n_errors;

  execute_mdu #(.XLEN(32), .FAST_MUL(0)) dut (
    .clk(clk), .reset_n(reset_n),
    .PIP_pc_i(pc), .PIP_operand1_i(op1), .PIP_operand2_i(op2), .PIP_immediate_i(imm),
    .PIP_rd_i(rd), .PIP_aluOper_i(alu_op),
    .PIP_use_imm_i(use_imm), .PIP_use_pc_i(use_pc), .PIP_use_zero_i(use_zero),
    .PIP_md_valid_i(md_valid), .PIP_md_oper_i(md_op),
    .PIP_bnj_oper_i(bnj_op), .PIP_is_bnj_i(is_bnj), .PIP_bnj_neg_i(bnj_neg),
    .PIP_memOper_i(mem_op), .PIP_use_mem_i(use_mem), .PIP_write_reg_i(write_reg), .PIP_TRAP_i(trap),
    .use_EX_MEM_rs1_i(fw_em1), .use_EX_MEM_rs2_i(fw_em2),
    .use_MEM_WB_rs1_i(fw_mw1), .use_MEM_WB_rs2_i(fw_mw2),
    .EX_MEM_operand_i(em_val), .MEM_WB_operand_i(mw_val),
    .PIP_memOper_o(mem_op_o), .PIP_alu_result_o(alu_o), .PIP_second_operand_o(second_o),
    .PIP_use_mem_o(use_mem_o), .PIP_write_reg_o(write_reg_o), .PIP_TRAP_o(trap_o),
    .PIP_rd_o(rd_o), .PC_load_target_o(load_o), .PC_target_address_o(target_o),
    .stall_o(stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nop();
    pc = 32'd0; op1 = 32'd0; op2 = 32'd0; imm = 32'd0; rd = 5'd0; alu_op = 4'd0;
    use_imm = 1'b0; use_pc = 1'b0; use_zero = 1'b0; md_valid = 1'b0; md_op = 3'd0;
    bnj_op = 2'd0; is_bnj = 1'b0; bnj_neg = 1'b0; mem_op = 5'd0; use_mem = 1'b0;
    write_reg = 1'b0; trap = 1'b0; fw_em1 = 1'b0; fw_em2 = 1'b0; fw_mw1 = 1'b0;
    fw_mw2 = 1'b0; em_val = 32'd0; mw_val = 32'd0;
  endtask

  // Single ALU instruction: drive, one edge, check the EX/MEM result
  task automatic alu(input string tag, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp);
    nop();
    alu_op = op; op1 = a; op2 = b; write_reg = 1'b1; rd = 5'd5;
    @(posedge clk); #1;
    check(tag, {32'd0, alu_o}, {32'd0, exp});
    nop();
  endtask

  // M-extension op held in ID/EX until the stall drops; checks latency and result
  task automatic md(input string tag, input logic [2:0] oper, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] exp,
                    input int exp_stall, input bit fwd);
    int  stall_cnt;
    int  edges;
    bit  done;
    nop();
    md_valid = 1'b1; md_op = oper; op2 = b; write_reg = 1'b1; rd = 5'd7;
    if (fwd) begin
      fw_em1 = 1'b1; em_val = a; op1 = 32'h0000_0005;
    end else begin
      op1 = a;
    end
    stall_cnt = 0; edges = 0; done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (!stall_o) begin
        done = 1'b1;
      end else begin
        stall_cnt++;
        @(posedge clk); edges++; #1;
        if (edges == 1) begin
          check({tag, "_bubble"}, {63'd0, write_reg_o}, 64'd0);
          if (fwd) begin
            fw_em1 = 1'b0; em_val = 32'hDEAD_BEEF;
          end
        end
      end
    end
    @(posedge clk); edges++; #1;
    check({tag, "_res"}, {32'd0, alu_o}, {32'd0, exp});
    check({tag, "_wr"}, {59'd0, write_reg_o, rd_o}, {59'd0, 1'b1, 5'd7});
    check({tag, "_stall"}, 64'(stall_cnt), 64'(exp_stall));
    check({tag, "_edges"}, 64'(edges), 64'(exp_stall + 1));
    nop();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    nop();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_alu", {32'd0, alu_o}, 64'd0);
    check("rst_ctl", {56'd0, write_reg_o, trap_o, use_mem_o, rd_o}, 64'd0);
    check("rst_stall", {63'd0, stall_o}, 64'd0);
    reset_n = 1'b1;

    // ALU vectors (shift amount uses only the low 5 bits of 0x24)
    alu("add",  4'd0, 32'd5, 32'd7, 32'd12);
    alu("sub",  4'd1, 32'd5, 32'd7, 32'hFFFF_FFFE);
    alu("slt",  4'd5, 32'hFFFF_FFFF, 32'd1, 32'd1);
    alu("sltu", 4'd6, 32'hFFFF_FFFF, 32'd1, 32'd0);
    alu("sra",  4'd9, 32'h8000_0000, 32'h24, 32'hF800_0000);
    alu("srl",  4'd10, 32'h8000_0000, 32'h24, 32'h0800_0000);
    alu("sll",  4'd8, 32'd1, 32'd31, 32'h8000_0000);

    // Conditional branch on SEQ, then the inverted condition
    nop();
    is_bnj = 1'b1; alu_op = 4'd7; op1 = 32'd9; op2 = 32'd9; pc = 32'h100; imm = 32'h20;
    #1;
    check("beq_load", {63'd0, load_o}, 64'd1);
    check("beq_tgt", {32'd0, target_o}, 64'h120);
    bnj_neg = 1'b1;
    #1;
    check("bne_load", {63'd0, load_o}, 64'd0);

    // Register-relative jump with link
    nop();
    is_bnj = 1'b1; bnj_op = 2'b11; op1 = 32'h1000; imm = 32'd4; pc = 32'h200; write_reg = 1'b1;
    #1;
    check("jalr_load", {63'd0, load_o}, 64'd1);
    check("jalr_tgt", {32'd0, target_o}, 64'h1004);
    @(posedge clk); #1;
    check("jalr_link", {32'd0, alu_o}, 64'h204);

    // Forwarding priority: EX/MEM over MEM/WB over register value
    nop();
    fw_em2 = 1'b1; fw_mw2 = 1'b1; fw_mw1 = 1'b1; em_val = 32'hAAAA; mw_val = 32'hBBBB;
    op1 = 32'd1; op2 = 32'hCCCC; alu_op = 4'd0;
    @(posedge clk); #1;
    check("fwd_sum", {32'd0, alu_o}, 64'h16665);
    check("fwd_store", {32'd0, second_o}, 64'hAAAA);

    // Trapping M-op is forwarded as a normal instruction without stalling
    nop();
    md_valid = 1'b1; md_op = 3'd4; trap = 1'b1; op1 = 32'd10; op2 = 32'd0;
    #1;
    check("trap_nostall", {63'd0, stall_o}, 64'd0);
    @(posedge clk); #1;
    check("trap_fwd", {31'd0, trap_o, alu_o}, {31'd0, 1'b1, 32'd10});
    nop();

    // Iterative multiplies
    md("mul",    3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b0);
    md("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0);
    md("mulh",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, 1'b0);
    md("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1'b0);

    // Iterative divides with sign correction
    md("rem",  3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b0);
    md("div",  3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0);
    md("divu", 3'd5, 32'd100, 32'd7, 32'd14, 33, 1'b0);

    // Special cases finish after a single stall cycle
    md("divu0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
    md("remu0", 3'd7, 32'd5, 32'd0, 32'd5, 1, 1'b0);
    md("divov", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
    md("remov", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b0);

    // ADD x1 then DIV x2 = x1 / x3 using a one-cycle EX/MEM forward
    nop();
    op1 = 32'd10; imm = 32'd20; use_imm = 1'b1; alu_op = 4'd0; write_reg = 1'b1; rd = 5'd1;
    @(posedge clk); #1;
    check("fw_add", {32'd0, alu_o}, 64'd30);
    md("fw_div", 3'd4, 32'd30, 32'd7, 32'd4, 33, 1'b1);

    // Reset during BUSY iteration 10 abandons the op
    nop();
    md_valid = 1'b1; md_op = 3'd4; op1 = 32'd100; op2 = 32'd7; write_reg = 1'b1; rd = 5'd7;
    repeat (11) @(posedge clk);
    #1;
    check("busy_stall", {63'd0, stall_o}, 64'd1);
    reset_n = 1'b0;
    nop();
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("rst2_stall", {63'd0, stall_o}, 64'd0);
    check("rst2_out", {27'd0, write_reg_o, rd_o, alu_o}, 64'd0);
    md("post_rst", 3'd4, 32'd100, 32'd7, 32'd14, 33, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
